// File: rtl/aes_xif_pkg.sv
// Shared AES32 XIF definitions: operation encoding, issue-queue entry state,
// entry control struct and the AES32 opcode / funct5 constants that the
// decoder, the issue queue and the execute stage all agree on.
package aes_xif_pkg;

  typedef enum logic [1:0] {
    DSI  = 2'd0,
    DSMI = 2'd1,
    ESI  = 2'd2,
    ESMI = 2'd3
  } aes_op_e;

  typedef enum logic [1:0] {
    IQ_FREE      = 2'd0,
    IQ_ISSUED    = 2'd1,
    IQ_COMMITTED = 2'd2,
    IQ_KILLED    = 2'd3
  } iq_state_e;

  // Fixed-width part of an entry; id and operands are sized by the queue's
  // parameters and are stored next to this struct inside the queue.
  typedef struct packed {
    iq_state_e  state;
    aes_op_e    op;
    logic [1:0] bs;
    logic [4:0] rd;
  } iq_entry_t;

  localparam logic [6:0] AES_OPCODE       = 7'b0110011;
  localparam logic [4:0] AES_FUNCT5_DSI   = 5'b10101;
  localparam logic [4:0] AES_FUNCT5_DSMI  = 5'b10111;
  localparam logic [4:0] AES_FUNCT5_ESI   = 5'b10001;
  localparam logic [4:0] AES_FUNCT5_ESMI  = 5'b10011;

endpackage

// File: rtl/aes_issue_queue.sv
// AES32 issue queue: buffers accepted instructions between XIF issue and the
// AES execute stage. Entries wait for their commit transaction; killed entries
// are dropped silently, committed ones are presented in order with valid/ready.
//
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   iss_valid_i / iss_ready_o     issue handshake, iss_id/op/bs/rd/rs1/rs2_i payload
//   commit_valid_i, commit_id_i,  XIF commit transaction (kill flag selects drop)
//   commit_kill_i
//   exe_valid_o / exe_ready_i     execute handshake, exe_* carry the head entry
//   count_o                       occupied entries
//   err_o                         sticky: commit matched a younger ISSUED entry
//
// Build option: define AES_IQ_KILL_FLUSH_EN so that a matched kill also kills
// every younger ISSUED entry (pipeline flush). Default: only the matched entry.
module aes_issue_queue
  import aes_xif_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned ID_WIDTH = 4,
  parameter int unsigned RS_WIDTH = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       iss_valid_i,
  output logic                       iss_ready_o,
  input  logic [ID_WIDTH-1:0]        iss_id_i,
  input  logic [1:0]                 iss_op_i,
  input  logic [1:0]                 iss_bs_i,
  input  logic [4:0]                 iss_rd_i,
  input  logic [RS_WIDTH-1:0]        iss_rs1_i,
  input  logic [RS_WIDTH-1:0]        iss_rs2_i,
  input  logic                       commit_valid_i,
  input  logic [ID_WIDTH-1:0]        commit_id_i,
  input  logic                       commit_kill_i,
  output logic                       exe_valid_o,
  input  logic                       exe_ready_i,
  output logic [ID_WIDTH-1:0]        exe_id_o,
  output logic [1:0]                 exe_op_o,
  output logic [1:0]                 exe_bs_o,
  output logic [4:0]                 exe_rd_o,
  output logic [RS_WIDTH-1:0]        exe_rs1_o,
  output logic [RS_WIDTH-1:0]        exe_rs2_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       err_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

`ifdef AES_IQ_KILL_FLUSH_EN
  localparam bit KillFlush = 1'b1;
`else
  localparam bit KillFlush = 1'b0;
`endif

  iq_entry_t             ctrl_q [DEPTH];
  logic [ID_WIDTH-1:0]   id_q   [DEPTH];
  logic [RS_WIDTH-1:0]   rs1_q  [DEPTH];
  logic [RS_WIDTH-1:0]   rs2_q  [DEPTH];

  logic [PTR_W-1:0] head_q, tail_q, cptr_q;
  logic [CNT_W-1:0] count_q;
  // ISSUED entries are contiguous from cptr_q, so their number fully
  // describes the commit window (cptr_q == tail_q alone is ambiguous).
  logic [CNT_W-1:0] n_iss_q;
  logic             err_q;

  logic      enq, deq;
  logic      cm_oldest, cm_direct, cm_young, flush;
  iq_state_e cm_state;

  assign iss_ready_o = (count_q != CNT_W'(DEPTH));
  assign enq         = iss_valid_i & iss_ready_o;

  assign exe_valid_o = (ctrl_q[head_q].state == IQ_COMMITTED);
  assign deq         = (exe_valid_o & exe_ready_i) | (ctrl_q[head_q].state == IQ_KILLED);

  assign cm_state  = commit_kill_i ? IQ_KILLED : IQ_COMMITTED;
  assign cm_oldest = commit_valid_i && (n_iss_q != '0) && (id_q[cptr_q] == commit_id_i);
  assign cm_direct = commit_valid_i && (n_iss_q == '0) && enq && (iss_id_i == commit_id_i);
  assign flush     = KillFlush && cm_oldest && commit_kill_i;

  always_comb begin
    cm_young = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (ctrl_q[i].state == IQ_ISSUED && PTR_W'(i) != cptr_q && id_q[i] == commit_id_i)
        cm_young = 1'b1;
    end
  end

  // Head data is only meaningful while valid; gating keeps idle outputs at 0.
  assign exe_id_o  = exe_valid_o ? id_q[head_q]        : '0;
  assign exe_op_o  = exe_valid_o ? ctrl_q[head_q].op   : '0;
  assign exe_bs_o  = exe_valid_o ? ctrl_q[head_q].bs   : '0;
  assign exe_rd_o  = exe_valid_o ? ctrl_q[head_q].rd   : '0;
  assign exe_rs1_o = exe_valid_o ? rs1_q[head_q]       : '0;
  assign exe_rs2_o = exe_valid_o ? rs2_q[head_q]       : '0;
  assign count_o   = count_q;
  assign err_o     = err_q;

  // Writes below never target the same entry in one cycle: flush touches only
  // ISSUED entries other than cptr, the head being freed is COMMITTED/KILLED,
  // and the tail is FREE whenever it is written.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < DEPTH; i++) ctrl_q[i] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      cptr_q  <= '0;
      count_q <= '0;
      n_iss_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (flush) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          if (ctrl_q[i].state == IQ_ISSUED && PTR_W'(i) != cptr_q)
            ctrl_q[i].state <= IQ_KILLED;
        end
      end
      if (cm_oldest) ctrl_q[cptr_q].state <= cm_state;
      if (deq) begin
        ctrl_q[head_q].state <= IQ_FREE;
        head_q <= head_q + 1'b1;
      end
      if (enq) begin
        ctrl_q[tail_q] <= '{state: (cm_direct ? cm_state : IQ_ISSUED),
                            op:    aes_op_e'(iss_op_i),
                            bs:    iss_bs_i,
                            rd:    iss_rd_i};
        tail_q <= tail_q + 1'b1;
      end

      if (flush) begin
        cptr_q  <= tail_q;
        n_iss_q <= CNT_W'(enq);
      end else begin
        if (cm_oldest || cm_direct) cptr_q <= cptr_q + 1'b1;
        n_iss_q <= n_iss_q + CNT_W'(enq & ~cm_direct) - CNT_W'(cm_oldest);
      end

      count_q <= count_q + CNT_W'(enq) - CNT_W'(deq);
      if (commit_valid_i && !cm_oldest && cm_young) err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq) begin
      id_q[tail_q]  <= iss_id_i;
      rs1_q[tail_q] <= iss_rs1_i;
      rs2_q[tail_q] <= iss_rs2_i;
    end
  end

endmodule

// File: tb/tb_aes_issue_queue.sv
// Bench for aes_issue_queue: an in-order queue model checked every cycle plus
// literal expectations at the key points of each scenario.
module tb_aes_issue_queue;

  localparam int DEPTH = 4;
  localparam int S_ISS = 1, S_COM = 2, S_KIL = 3;

  logic        clk = 1'b0, rst_ni = 1'b0;
  logic        iss_valid = 1'b0, iss_ready;
  logic [3:0]  iss_id = '0;
  logic [1:0]  iss_op = '0, iss_bs = '0;
  logic [4:0]  iss_rd = '0;
  logic [31:0] iss_rs1 = '0, iss_rs2 = '0;
  logic        commit_valid = 1'b0, commit_kill = 1'b0;
  logic [3:0]  commit_id = '0;
  logic        exe_valid, exe_ready = 1'b0;
  logic [3:0]  exe_id;
  logic [1:0]  exe_op, exe_bs;
  logic [4:0]  exe_rd;
  logic [31:0] exe_rs1, exe_rs2;
  logic [2:0]  count;
  logic        err;

  int checks = 0, errors = 0;

  aes_issue_queue #(.DEPTH(DEPTH), .ID_WIDTH(4), .RS_WIDTH(32)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .iss_valid_i(iss_valid), .iss_ready_o(iss_ready), .iss_id_i(iss_id),
    .iss_op_i(iss_op), .iss_bs_i(iss_bs), .iss_rd_i(iss_rd),
    .iss_rs1_i(iss_rs1), .iss_rs2_i(iss_rs2),
    .commit_valid_i(commit_valid), .commit_id_i(commit_id), .commit_kill_i(commit_kill),
    .exe_valid_o(exe_valid), .exe_ready_i(exe_ready),
    .exe_id_o(exe_id), .exe_op_o(exe_op), .exe_bs_o(exe_bs), .exe_rd_o(exe_rd),
    .exe_rs1_o(exe_rs1), .exe_rs2_o(exe_rs2),
    .count_o(count), .err_o(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a plain queue of in-flight instructions, oldest first.
  typedef struct {
    int          id, op, bs, rd, st;
    logic [31:0] rs1, rs2;
  } m_t;
  m_t mq[$];
  bit m_err;
  int m_old;
  bit m_enq, m_deq, m_direct;
  m_t m_ne;

  always @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      mq.delete();
      m_err = 1'b0;
    end else begin
      m_enq = iss_valid && (mq.size() < DEPTH);
      m_old = -1;
      foreach (mq[i]) if (mq[i].st == S_ISS && m_old < 0) m_old = i;
      m_deq = (mq.size() > 0) && (mq[0].st == S_KIL || (mq[0].st == S_COM && exe_ready));
      m_direct = 1'b0;
      if (commit_valid) begin
        if (m_old >= 0 && mq[m_old].id == int'(commit_id)) begin
          mq[m_old].st = commit_kill ? S_KIL : S_COM;
`ifdef AES_IQ_KILL_FLUSH_EN
          if (commit_kill)
            for (int j = m_old + 1; j < mq.size(); j++)
              if (mq[j].st == S_ISS) mq[j].st = S_KIL;
`endif
        end else if (m_old < 0) begin
          if (m_enq && iss_id == commit_id) m_direct = 1'b1;
        end else begin
          foreach (mq[i]) if (mq[i].st == S_ISS && mq[i].id == int'(commit_id)) m_err = 1'b1;
        end
      end
      if (m_deq) void'(mq.pop_front());
      if (m_enq) begin
        m_ne.id = int'(iss_id); m_ne.op = int'(iss_op); m_ne.bs = int'(iss_bs);
        m_ne.rd = int'(iss_rd); m_ne.rs1 = iss_rs1; m_ne.rs2 = iss_rs2;
        m_ne.st = m_direct ? (commit_kill ? S_KIL : S_COM) : S_ISS;
        mq.push_back(m_ne);
      end
    end
  end

  // Per-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_ni) begin
      chk("count", 32'(count), 32'(mq.size()));
      chk("iss_ready", 32'(iss_ready), 32'(mq.size() != DEPTH));
      chk("exe_valid", 32'(exe_valid), 32'(mq.size() > 0 && mq[0].st == S_COM));
      chk("err", 32'(err), 32'(m_err));
      if (mq.size() > 0 && mq[0].st == S_COM) begin
        chk("exe_id", 32'(exe_id), 32'(mq[0].id));
        chk("exe_op", 32'(exe_op), 32'(mq[0].op));
        chk("exe_bs", 32'(exe_bs), 32'(mq[0].bs));
        chk("exe_rd", 32'(exe_rd), 32'(mq[0].rd));
        chk("exe_rs1", exe_rs1, mq[0].rs1);
        chk("exe_rs2", exe_rs2, mq[0].rs2);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int id, input int op, input logic [31:0] rs1);
    iss_valid = 1'b1; iss_id = 4'(id); iss_op = 2'(op); iss_bs = 2'(id);
    iss_rd = 5'(id + 10); iss_rs1 = rs1; iss_rs2 = ~rs1;
    cyc();
    iss_valid = 1'b0;
  endtask

  task automatic commit(input int id, input bit kill);
    commit_valid = 1'b1; commit_id = 4'(id); commit_kill = kill;
    cyc();
    commit_valid = 1'b0; commit_kill = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    repeat (2) cyc();
    // Reset state
    chk("rst_count", 32'(count), 0);
    chk("rst_iss_ready", 32'(iss_ready), 1);
    chk("rst_exe_valid", 32'(exe_valid), 0);
    chk("rst_exe_id", 32'(exe_id), 0);
    chk("rst_exe_rs1", exe_rs1, 0);
    chk("rst_err", 32'(err), 0);
    rst_ni = 1'b1;
    cyc();

    // 1: issue, commit two cycles later, execute
    issue(3, 2, 32'h01234567);
    chk("t1_no_valid_before_commit", 32'(exe_valid), 0);
    cyc();
    commit(3, 1'b0);
    chk("t1_valid", 32'(exe_valid), 1);
    chk("t1_id", 32'(exe_id), 3);
    chk("t1_op", 32'(exe_op), 2);
    chk("t1_rs1", exe_rs1, 32'h01234567);
    exe_ready = 1'b1; cyc(); exe_ready = 1'b0;
    chk("t1_count", 32'(count), 0);

    // 2: fill to DEPTH, fifth issue refused, one dequeue reopens
    for (int i = 1; i <= 4; i++) issue(i, i - 1, 32'h1000 + 32'(i));
    chk("t2_count_full", 32'(count), 4);
    chk("t2_model_full", 32'(mq.size()), 4);
    chk("t2_ready_full", 32'(iss_ready), 0);
    issue(5, 0, 32'hdead);
    chk("t2_count_after_5th", 32'(count), 4);
    commit(1, 1'b0);
    exe_ready = 1'b1; cyc(); exe_ready = 1'b0;
    chk("t2_ready_reopen", 32'(iss_ready), 1);
    chk("t2_count_3", 32'(count), 3);
    exe_ready = 1'b1;
    commit(2, 1'b0); commit(3, 1'b0); commit(4, 1'b0);
    cyc(); cyc();
    exe_ready = 1'b0;
    chk("t2_drained", 32'(count), 0);

    // 3: killed entry is never presented
    issue(5, 1, 32'h55); issue(6, 3, 32'h66);
    commit(5, 1'b1);
    commit(6, 1'b0);
    chk("t3_valid", 32'(exe_valid), 1);
    chk("t3_id", 32'(exe_id), 6);
    chk("t3_count", 32'(count), 1);
    exe_ready = 1'b1; cyc(); exe_ready = 1'b0;
    chk("t3_drained", 32'(count), 0);

    // 4: unknown id ignored; out-of-order commit flags err
    commit(9, 1'b0);
    chk("t4_err_unknown", 32'(err), 0);
    chk("t4_count_unknown", 32'(count), 0);
    issue(1, 0, 32'h11); issue(2, 0, 32'h22);
    commit(2, 1'b0);
    chk("t4_err_set", 32'(err), 1);
    chk("t4_model_err", 32'(m_err), 1);
    chk("t4_count", 32'(count), 2);
    cyc();
    chk("t4_no_valid", 32'(exe_valid), 0);
    exe_ready = 1'b1;
    commit(1, 1'b0); commit(2, 1'b0);
    cyc(); cyc();
    exe_ready = 1'b0;
    chk("t4_drained", 32'(count), 0);
    chk("t4_err_sticky", 32'(err), 1);

    // 5: same-cycle issue and commit into an empty queue
    iss_valid = 1'b1; iss_id = 4'd7; iss_op = 2'd3; iss_bs = 2'd2; iss_rd = 5'd17;
    iss_rs1 = 32'hcafef00d; iss_rs2 = 32'h12345678;
    commit_valid = 1'b1; commit_id = 4'd7; commit_kill = 1'b0;
    cyc();
    iss_valid = 1'b0; commit_valid = 1'b0;
    chk("t5_valid", 32'(exe_valid), 1);
    chk("t5_id", 32'(exe_id), 7);
    chk("t5_rs2", exe_rs2, 32'h12345678);
    exe_ready = 1'b1; cyc(); exe_ready = 1'b0;
    chk("t5_drained", 32'(count), 0);

    // 6: kill of the oldest with younger entries pending
    issue(1, 0, 32'ha1); issue(2, 1, 32'ha2); issue(3, 2, 32'ha3);
    commit(1, 1'b1);
    repeat (3) cyc();
`ifdef AES_IQ_KILL_FLUSH_EN
    chk("t6_count_flush", 32'(count), 0);
    chk("t6_model_flush", 32'(mq.size()), 0);
`else
    chk("t6_count_noflush", 32'(count), 2);
    chk("t6_model_noflush", 32'(mq.size()), 2);
`endif
    exe_ready = 1'b1;
    commit(2, 1'b0); commit(3, 1'b0);
    cyc(); cyc();
    exe_ready = 1'b0;
    chk("t6_drained", 32'(count), 0);

    // 7: asynchronous reset mid-operation
    issue(4, 0, 32'h44); issue(5, 0, 32'h45);
    chk("t7_count_before", 32'(count), 2);
    rst_ni = 1'b0;
    #1;
    chk("t7_count_async", 32'(count), 0);
    chk("t7_ready_async", 32'(iss_ready), 1);
    chk("t7_err_async", 32'(err), 0);
    cyc();
    rst_ni = 1'b1;
    repeat (3) cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
